// File: rtl/rs_alu.sv
// ALU reservation station with 16 entries. It accepts two dispatch writes per cycle, wakes
// entries up from two CDB ports, and issues the lowest ready entry. Branch flush and release act on spec tags.
module rs_alu #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int CTL_W   = 8,
  parameter int SPEC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  // dispatch slot 1
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wsrc1_val1,
  input  logic [DATA_W-1:0] wsrc2_val1,
  input  logic [TAG_W-1:0]  wsrc1_tag1,
  input  logic [TAG_W-1:0]  wsrc2_tag1,
  input  logic              wsrc1_rdy1,
  input  logic              wsrc2_rdy1,
  input  logic [TAG_W-1:0]  wdst1,
  input  logic [CTL_W-1:0]  wctl1,
  input  logic [SPEC_W-1:0] wspec1,
  // dispatch slot 2
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wsrc1_val2,
  input  logic [DATA_W-1:0] wsrc2_val2,
  input  logic [TAG_W-1:0]  wsrc1_tag2,
  input  logic [TAG_W-1:0]  wsrc2_tag2,
  input  logic              wsrc1_rdy2,
  input  logic              wsrc2_rdy2,
  input  logic [TAG_W-1:0]  wdst2,
  input  logic [CTL_W-1:0]  wctl2,
  input  logic [SPEC_W-1:0] wspec2,
  output logic [ENTRIES-1:0] busy,
  // result broadcast
  input  logic              cdb_v0,
  input  logic [TAG_W-1:0]  cdb_tag0,
  input  logic [DATA_W-1:0] cdb_data0,
  input  logic              cdb_v1,
  input  logic [TAG_W-1:0]  cdb_tag1,
  input  logic [DATA_W-1:0] cdb_data1,
  // issue
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [DATA_W-1:0] iss_op1,
  output logic [DATA_W-1:0] iss_op2,
  output logic [TAG_W-1:0]  iss_dst,
  output logic [CTL_W-1:0]  iss_ctl,
  output logic [SPEC_W-1:0] iss_spec,
  // branch resolution
  input  logic              flush_v,
  input  logic [SPEC_W-1:0] flush_mask,
  input  logic              clr_v,
  input  logic [SPEC_W-1:0] clr_mask,
  output logic              err
);

  logic [ENTRIES-1:0] r_busy;
  logic               r_err;

  logic [DATA_W-1:0]  r_s1_val [ENTRIES];
  logic [DATA_W-1:0]  r_s2_val [ENTRIES];
  logic [TAG_W-1:0]   r_s1_tag [ENTRIES];
  logic [TAG_W-1:0]   r_s2_tag [ENTRIES];
  logic [ENTRIES-1:0] r_s1_rdy;
  logic [ENTRIES-1:0] r_s2_rdy;
  logic [TAG_W-1:0]   r_dst    [ENTRIES];
  logic [CTL_W-1:0]   r_ctl    [ENTRIES];
  logic [SPEC_W-1:0]  r_spec   [ENTRIES];

  // Returns {ready, value} for a dispatched source after same-cycle CDB bypass; port 0 wins.
  function automatic logic [DATA_W:0] src_fwd(
    input logic              rdy,
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] val,
    input logic              v0,
    input logic [TAG_W-1:0]  t0,
    input logic [DATA_W-1:0] d0,
    input logic              v1,
    input logic [TAG_W-1:0]  t1,
    input logic [DATA_W-1:0] d1
  );
    if (v0 && (t0 == tag))      src_fwd = {1'b1, d0};
    else if (v1 && (t1 == tag)) src_fwd = {1'b1, d1};
    else                        src_fwd = {rdy, val};
  endfunction

  logic [DATA_W:0] w_src1_slot1, w_src2_slot1, w_src1_slot2, w_src2_slot2;

  assign w_src1_slot1 = src_fwd(wsrc1_rdy1, wsrc1_tag1, wsrc1_val1,
                                cdb_v0, cdb_tag0, cdb_data0, cdb_v1, cdb_tag1, cdb_data1);
  assign w_src2_slot1 = src_fwd(wsrc2_rdy1, wsrc2_tag1, wsrc2_val1,
                                cdb_v0, cdb_tag0, cdb_data0, cdb_v1, cdb_tag1, cdb_data1);
  assign w_src1_slot2 = src_fwd(wsrc1_rdy2, wsrc1_tag2, wsrc1_val2,
                                cdb_v0, cdb_tag0, cdb_data0, cdb_v1, cdb_tag1, cdb_data1);
  assign w_src2_slot2 = src_fwd(wsrc2_rdy2, wsrc2_tag2, wsrc2_val2,
                                cdb_v0, cdb_tag0, cdb_data0, cdb_v1, cdb_tag1, cdb_data1);

  // Flush is judged on the spec bits as they stand before this cycle's release.
  logic              w_drop1, w_drop2, w_dup, w_err_now;
  logic [SPEC_W-1:0] w_wspec1, w_wspec2;

  assign w_drop1   = flush_v && |(wspec1 & flush_mask);
  assign w_drop2   = flush_v && |(wspec2 & flush_mask);
  assign w_dup     = we1 && we2 && (waddr1 == waddr2);
  assign w_wspec1  = clr_v ? (wspec1 & ~clr_mask) : wspec1;
  assign w_wspec2  = clr_v ? (wspec2 & ~clr_mask) : wspec2;
  assign w_err_now = (we1 && r_busy[waddr1]) || (we2 && r_busy[waddr2]) || w_dup;

  logic [ENTRIES-1:0] w_wr1, w_wr2, w_flush, w_elig, w_grant;
  logic [ADDR_W-1:0]  w_sel;
  logic               w_issue;

  // NOTE: every signal driven here gets a default before the loop; otherwise synthesis infers latches.
  always_comb begin
    w_wr1   = '0;
    w_wr2   = '0;
    w_flush = '0;
    w_elig  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_wr1[i]   = we1 && (waddr1 == ADDR_W'(i)) && !w_drop1;
      w_wr2[i]   = we2 && (waddr2 == ADDR_W'(i)) && !w_drop2 && !w_dup;
      w_flush[i] = flush_v && |(r_spec[i] & flush_mask);
      w_elig[i]  = r_busy[i] && r_s1_rdy[i] && r_s2_rdy[i] && !w_flush[i];
    end
  end

  // Scan from the top so the lowest eligible index is the last one assigned.
  always_comb begin
    w_sel = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = ADDR_W'(i);
    end
  end

  assign w_issue = iss_valid && iss_ready;

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_grant[i] = w_issue && (w_sel == ADDR_W'(i));
    end
  end

  assign iss_valid = |w_elig;
  assign iss_op1   = r_s1_val[w_sel];
  assign iss_op2   = r_s2_val[w_sel];
  assign iss_dst   = r_dst[w_sel];
  assign iss_ctl   = r_ctl[w_sel];
  assign iss_spec  = r_spec[w_sel];
  assign busy      = r_busy;
  assign err       = r_err;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // A write in the same cycle overrides issue or flush, because dispatch owns the entry from then on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_wr1[i] || w_wr2[i])        r_busy[i] <= 1'b1;
        else if (w_grant[i] || w_flush[i]) r_busy[i] <= 1'b0;
      end
      if (w_err_now) r_err <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; busy gates every use, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_wr1[i]) begin
        r_s1_rdy[i] <= w_src1_slot1[DATA_W];
        r_s1_val[i] <= w_src1_slot1[DATA_W-1:0];
        r_s2_rdy[i] <= w_src2_slot1[DATA_W];
        r_s2_val[i] <= w_src2_slot1[DATA_W-1:0];
        r_s1_tag[i] <= wsrc1_tag1;
        r_s2_tag[i] <= wsrc2_tag1;
        r_dst[i]    <= wdst1;
        r_ctl[i]    <= wctl1;
        r_spec[i]   <= w_wspec1;
      end else if (w_wr2[i]) begin
        r_s1_rdy[i] <= w_src1_slot2[DATA_W];
        r_s1_val[i] <= w_src1_slot2[DATA_W-1:0];
        r_s2_rdy[i] <= w_src2_slot2[DATA_W];
        r_s2_val[i] <= w_src2_slot2[DATA_W-1:0];
        r_s1_tag[i] <= wsrc1_tag2;
        r_s2_tag[i] <= wsrc2_tag2;
        r_dst[i]    <= wdst2;
        r_ctl[i]    <= wctl2;
        r_spec[i]   <= w_wspec2;
      end else begin
        if (r_busy[i] && !r_s1_rdy[i]) begin
          if (cdb_v0 && (cdb_tag0 == r_s1_tag[i])) begin
            r_s1_val[i] <= cdb_data0;
            r_s1_rdy[i] <= 1'b1;
          end else if (cdb_v1 && (cdb_tag1 == r_s1_tag[i])) begin
            r_s1_val[i] <= cdb_data1;
            r_s1_rdy[i] <= 1'b1;
          end
        end
        if (r_busy[i] && !r_s2_rdy[i]) begin
          if (cdb_v0 && (cdb_tag0 == r_s2_tag[i])) begin
            r_s2_val[i] <= cdb_data0;
            r_s2_rdy[i] <= 1'b1;
          end else if (cdb_v1 && (cdb_tag1 == r_s2_tag[i])) begin
            r_s2_val[i] <= cdb_data1;
            r_s2_rdy[i] <= 1'b1;
          end
        end
        if (clr_v) r_spec[i] <= r_spec[i] & ~clr_mask;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Testbench for rs_alu. Directed scenarios are checked against constants; a randomized run
// is checked against a behavioural model of the station kept as an array of entry records.
module tb_rs_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        we1, we2;
  logic [3:0]  waddr1, waddr2;
  logic [31:0] wsrc1_val1, wsrc2_val1, wsrc1_val2, wsrc2_val2;
  logic [5:0]  wsrc1_tag1, wsrc2_tag1, wsrc1_tag2, wsrc2_tag2;
  logic        wsrc1_rdy1, wsrc2_rdy1, wsrc1_rdy2, wsrc2_rdy2;
  logic [5:0]  wdst1, wdst2;
  logic [7:0]  wctl1, wctl2;
  logic [3:0]  wspec1, wspec2;
  logic [15:0] busy;
  logic        cdb_v0, cdb_v1;
  logic [5:0]  cdb_tag0, cdb_tag1;
  logic [31:0] cdb_data0, cdb_data1;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_op1, iss_op2;
  logic [5:0]  iss_dst;
  logic [7:0]  iss_ctl;
  logic [3:0]  iss_spec;
  logic        flush_v, clr_v;
  logic [3:0]  flush_mask, clr_mask;
  logic        err;

  int checks = 0;
  int errors = 0;

  rs_alu dut (
    .clk(clk), .reset(reset),
    .we1(we1), .waddr1(waddr1), .wsrc1_val1(wsrc1_val1), .wsrc2_val1(wsrc2_val1),
    .wsrc1_tag1(wsrc1_tag1), .wsrc2_tag1(wsrc2_tag1), .wsrc1_rdy1(wsrc1_rdy1),
    .wsrc2_rdy1(wsrc2_rdy1), .wdst1(wdst1), .wctl1(wctl1), .wspec1(wspec1),
    .we2(we2), .waddr2(waddr2), .wsrc1_val2(wsrc1_val2), .wsrc2_val2(wsrc2_val2),
    .wsrc1_tag2(wsrc1_tag2), .wsrc2_tag2(wsrc2_tag2), .wsrc1_rdy2(wsrc1_rdy2),
    .wsrc2_rdy2(wsrc2_rdy2), .wdst2(wdst2), .wctl2(wctl2), .wspec2(wspec2),
    .busy(busy),
    .cdb_v0(cdb_v0), .cdb_tag0(cdb_tag0), .cdb_data0(cdb_data0),
    .cdb_v1(cdb_v1), .cdb_tag1(cdb_tag1), .cdb_data1(cdb_data1),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_dst(iss_dst), .iss_ctl(iss_ctl), .iss_spec(iss_spec),
    .flush_v(flush_v), .flush_mask(flush_mask), .clr_v(clr_v), .clr_mask(clr_mask),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        busy;
    logic [31:0] v1, v2;
    logic [5:0]  t1, t2;
    logic        r1, r2;
    logic [5:0]  dst;
    logic [7:0]  ctl;
    logic [3:0]  spec;
  } ent_t;

  ent_t m [16];
  logic m_err;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
    m_err = 1'b0;
  endtask

  function automatic int model_pick();
    for (int i = 0; i < 16; i++)
      if (m[i].busy && m[i].r1 && m[i].r2 && !(flush_v && (m[i].spec & flush_mask) != 0))
        return i;
    return -1;
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = m[i].busy;
    return b;
  endfunction

  function automatic void fwd(input logic rdy, input logic [5:0] tag, input logic [31:0] val,
                              output logic r, output logic [31:0] v);
    r = rdy;
    v = val;
    if (cdb_v0 && cdb_tag0 == tag) begin r = 1'b1; v = cdb_data0; end
    else if (cdb_v1 && cdb_tag1 == tag) begin r = 1'b1; v = cdb_data1; end
  endfunction

  function automatic ent_t mk(input logic [31:0] a_v, b_v, input logic [5:0] a_t, b_t,
                              input logic a_r, b_r, input logic [5:0] d,
                              input logic [7:0] c, input logic [3:0] s);
    ent_t e;
    e.busy = 1'b1;
    fwd(a_r, a_t, a_v, e.r1, e.v1);
    fwd(b_r, b_t, b_v, e.r2, e.v2);
    e.t1 = a_t;
    e.t2 = b_t;
    e.dst = d;
    e.ctl = c;
    e.spec = clr_v ? (s & ~clr_mask) : s;
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_clock();
    ent_t n [16];
    int p;
    n = m;
    p = model_pick();
    for (int i = 0; i < 16; i++) begin
      if (p == i && iss_ready) n[i].busy = 1'b0;
      if (flush_v && (m[i].spec & flush_mask) != 0) n[i].busy = 1'b0;
      if (m[i].busy && !m[i].r1) begin
        if (cdb_v0 && cdb_tag0 == m[i].t1) begin n[i].r1 = 1'b1; n[i].v1 = cdb_data0; end
        else if (cdb_v1 && cdb_tag1 == m[i].t1) begin n[i].r1 = 1'b1; n[i].v1 = cdb_data1; end
      end
      if (m[i].busy && !m[i].r2) begin
        if (cdb_v0 && cdb_tag0 == m[i].t2) begin n[i].r2 = 1'b1; n[i].v2 = cdb_data0; end
        else if (cdb_v1 && cdb_tag1 == m[i].t2) begin n[i].r2 = 1'b1; n[i].v2 = cdb_data1; end
      end
      if (clr_v) n[i].spec = m[i].spec & ~clr_mask;
    end
    if (we1) begin
      if (m[waddr1].busy) m_err = 1'b1;
      if (!(flush_v && (wspec1 & flush_mask) != 0))
        n[waddr1] = mk(wsrc1_val1, wsrc2_val1, wsrc1_tag1, wsrc2_tag1, wsrc1_rdy1, wsrc2_rdy1,
                       wdst1, wctl1, wspec1);
    end
    if (we2) begin
      if (we1 && waddr1 == waddr2) m_err = 1'b1;
      else begin
        if (m[waddr2].busy) m_err = 1'b1;
        if (!(flush_v && (wspec2 & flush_mask) != 0))
          n[waddr2] = mk(wsrc1_val2, wsrc2_val2, wsrc1_tag2, wsrc2_tag2, wsrc1_rdy2, wsrc2_rdy2,
                         wdst2, wctl2, wspec2);
      end
    end
    m = n;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we1 = 0; we2 = 0; waddr1 = 0; waddr2 = 0;
    wsrc1_val1 = 0; wsrc2_val1 = 0; wsrc1_val2 = 0; wsrc2_val2 = 0;
    wsrc1_tag1 = 0; wsrc2_tag1 = 0; wsrc1_tag2 = 0; wsrc2_tag2 = 0;
    wsrc1_rdy1 = 0; wsrc2_rdy1 = 0; wsrc1_rdy2 = 0; wsrc2_rdy2 = 0;
    wdst1 = 0; wdst2 = 0; wctl1 = 0; wctl2 = 0; wspec1 = 0; wspec2 = 0;
    cdb_v0 = 0; cdb_v1 = 0; cdb_tag0 = 0; cdb_tag1 = 0; cdb_data0 = 0; cdb_data1 = 0;
    iss_ready = 0; flush_v = 0; flush_mask = 0; clr_v = 0; clr_mask = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write1(input logic [3:0] a, input logic [31:0] v1, v2, input logic [5:0] t1, t2,
                        input logic r1, r2, input logic [5:0] d, input logic [7:0] c,
                        input logic [3:0] s);
    we1 = 1; waddr1 = a; wsrc1_val1 = v1; wsrc2_val1 = v2; wsrc1_tag1 = t1; wsrc2_tag1 = t2;
    wsrc1_rdy1 = r1; wsrc2_rdy1 = r2; wdst1 = d; wctl1 = c; wspec1 = s;
  endtask

  task automatic write2(input logic [3:0] a, input logic [31:0] v1, v2, input logic [5:0] t1, t2,
                        input logic r1, r2, input logic [5:0] d, input logic [7:0] c,
                        input logic [3:0] s);
    we2 = 1; waddr2 = a; wsrc1_val2 = v1; wsrc2_val2 = v2; wsrc1_tag2 = t1; wsrc2_tag2 = t2;
    wsrc1_rdy2 = r1; wsrc2_rdy2 = r2; wdst2 = d; wctl2 = c; wspec2 = s;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h want 0000", busy); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", iss_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_issue();
    write1(4'd3, 32'h1111_1111, 32'h2222_2222, 6'h01, 6'h02, 1, 1, 6'h2A, 8'h5C, 4'h0);
    #1;
    checks++; if (iss_valid !== 1'b0 || busy !== 16'h0) begin errors++;
      $display("FAIL basic_same_cycle: got valid=%b busy=%h want 0 0000", iss_valid, busy); end
    @(negedge clk);
    idle();
    iss_ready = 1;
    #1;
    checks++; if (busy !== 16'h0008) begin errors++; $display("FAIL basic_busy: got %h want 0008", busy); end
    checks++; if ({iss_valid, iss_op1, iss_op2, iss_dst, iss_ctl} !== {1'b1, 32'h1111_1111, 32'h2222_2222, 6'h2A, 8'h5C}) begin
      errors++; $display("FAIL basic_issue: got v=%b %h %h %h %h", iss_valid, iss_op1, iss_op2, iss_dst, iss_ctl); end
    @(negedge clk);
    iss_ready = 0;
    #1;
    checks++; if (busy !== 16'h0 || iss_valid !== 1'b0) begin errors++;
      $display("FAIL basic_drain: got busy=%h valid=%b want 0000 0", busy, iss_valid); end
  endtask

  task automatic test_cdb_wakeup();
    @(negedge clk);
    idle();
    write1(4'd5, 32'hA5A5_0001, 32'h0, 6'h01, 6'h12, 1, 0, 6'h05, 8'h01, 4'h0);
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy !== 16'h0020 || iss_valid !== 1'b0) begin errors++;
      $display("FAIL wake_wait: got busy=%h valid=%b want 0020 0", busy, iss_valid); end
    @(negedge clk);
    cdb_v1 = 1; cdb_tag1 = 6'h12; cdb_data1 = 32'hDEAD_BEEF;
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_same_cycle: got %b want 0", iss_valid); end
    @(negedge clk);
    idle();
    iss_ready = 1;
    #1;
    checks++; if ({iss_valid, iss_op1, iss_op2} !== {1'b1, 32'hA5A5_0001, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL wake_issue: got v=%b op1=%h op2=%h want 1 a5a50001 deadbeef", iss_valid, iss_op1, iss_op2); end
    // Both ports broadcasting the waited-on tag: port 0 must win.
    @(negedge clk);
    idle();
    write1(4'd11, 32'h0, 32'h7777_7777, 6'h30, 6'h00, 0, 1, 6'h0B, 8'h02, 4'h0);
    @(negedge clk);
    idle();
    cdb_v0 = 1; cdb_tag0 = 6'h30; cdb_data0 = 32'hAAAA_0000;
    cdb_v1 = 1; cdb_tag1 = 6'h30; cdb_data1 = 32'hBBBB_0000;
    @(negedge clk);
    idle();
    iss_ready = 1;
    #1;
    checks++; if ({iss_valid, iss_op1} !== {1'b1, 32'hAAAA_0000}) begin errors++;
      $display("FAIL wake_port_priority: got v=%b op1=%h want 1 aaaa0000", iss_valid, iss_op1); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    idle();
    write1(4'd7, 32'h0, 32'h3333_3333, 6'h21, 6'h00, 0, 1, 6'h07, 8'h03, 4'h0);
    cdb_v0 = 1; cdb_tag0 = 6'h21; cdb_data0 = 32'hCAFE_F00D;
    @(negedge clk);
    idle();
    iss_ready = 1;
    #1;
    checks++; if ({iss_valid, iss_op1, iss_op2} !== {1'b1, 32'hCAFE_F00D, 32'h3333_3333}) begin errors++;
      $display("FAIL bypass: got v=%b op1=%h op2=%h want 1 cafef00d 33333333", iss_valid, iss_op1, iss_op2); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL bypass_drain: got %h want 0000", busy); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle();
    write1(4'd2, 32'h2, 32'h2, 6'h00, 6'h00, 1, 1, 6'h02, 8'h22, 4'b0010);
    write2(4'd9, 32'h9, 32'h9, 6'h00, 6'h00, 1, 1, 6'h09, 8'h99, 4'b0001);
    @(negedge clk);
    idle();
    flush_v = 1; flush_mask = 4'b0010;
    #1;
    checks++; if ({iss_valid, iss_dst, iss_spec} !== {1'b1, 6'h09, 4'b0001}) begin errors++;
      $display("FAIL flush_select: got v=%b dst=%h spec=%h want 1 09 1", iss_valid, iss_dst, iss_spec); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy !== 16'h0200) begin errors++; $display("FAIL flush_busy: got %h want 0200", busy); end
    iss_ready = 1;
    // A write carrying a flushed spec bit is dropped.
    write1(4'd4, 32'h4, 32'h4, 6'h00, 6'h00, 1, 1, 6'h04, 8'h44, 4'b0100);
    flush_v = 1; flush_mask = 4'b0100;
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL flush_drop_write: got %h want 0000", busy); end
  endtask

  task automatic test_full_err();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idle();
      write1(4'(2 * k), 32'(k), 32'(k), 6'h00, 6'h00, 1, 1, 6'(2 * k), 8'h00, 4'h0);
      write2(4'(2 * k + 1), 32'(k), 32'(k), 6'h00, 6'h00, 1, 1, 6'(2 * k + 1), 8'h00, 4'h0);
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({busy, err, iss_valid, iss_dst} !== {16'hFFFF, 1'b0, 1'b1, 6'h00}) begin errors++;
      $display("FAIL full: got busy=%h err=%b v=%b dst=%h want ffff 0 1 00", busy, err, iss_valid, iss_dst); end
    write1(4'd0, 32'h0, 32'h0, 6'h00, 6'h00, 1, 1, 6'h3F, 8'h00, 4'h0);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_err_sticky: got %b want 1", err); end
    do_reset();
    write1(4'd6, 32'h6161_6161, 32'h1, 6'h00, 6'h00, 1, 1, 6'h11, 8'h61, 4'h0);
    write2(4'd6, 32'h6262_6262, 32'h2, 6'h00, 6'h00, 1, 1, 6'h22, 8'h62, 4'h0);
    @(negedge clk);
    idle();
    #1;
    checks++; if ({err, busy, iss_valid, iss_dst, iss_op1} !== {1'b1, 16'h0040, 1'b1, 6'h11, 32'h6161_6161}) begin errors++;
      $display("FAIL dup_addr: got err=%b busy=%h v=%b dst=%h op1=%h", err, busy, iss_valid, iss_dst, iss_op1); end
    do_reset();
  endtask

  task automatic test_release();
    write1(4'd1, 32'h1, 32'h1, 6'h00, 6'h00, 1, 1, 6'h01, 8'h01, 4'b0001);
    @(negedge clk);
    idle();
    clr_v = 1; clr_mask = 4'b0001;
    @(negedge clk);
    idle();
    flush_v = 1; flush_mask = 4'b0001;
    #1;
    checks++; if ({iss_valid, iss_spec} !== {1'b1, 4'b0000}) begin errors++;
      $display("FAIL clr_then_flush: got v=%b spec=%h want 1 0", iss_valid, iss_spec); end
    @(negedge clk);
    idle();
    iss_ready = 1;
    #1;
    checks++; if ({busy, iss_valid} !== {16'h0002, 1'b1}) begin errors++;
      $display("FAIL clr_survive: got busy=%h v=%b want 0002 1", busy, iss_valid); end
    @(negedge clk);
    idle();
    // Same-cycle release and flush: the flush sees the spec bit first.
    write1(4'd1, 32'h1, 32'h1, 6'h00, 6'h00, 1, 1, 6'h01, 8'h01, 4'b0001);
    @(negedge clk);
    idle();
    clr_v = 1; clr_mask = 4'b0001; flush_v = 1; flush_mask = 4'b0001;
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL clr_flush_same_valid: got %b want 0", iss_valid); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL clr_flush_same_busy: got %h want 0000", busy); end
  endtask

  task automatic test_random();
    int q [$];
    int p;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      q.delete();
      for (int i = 0; i < 16; i++) if (!m[i].busy) q.push_back(i);
      we1 = (q.size() > 0) && ($urandom_range(0, 9) < 5);
      we2 = (q.size() > 0) && ($urandom_range(0, 9) < 4);
      waddr1 = (q.size() > 0) ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'd0;
      waddr2 = (q.size() > 0) ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'd0;
      if ($urandom_range(0, 63) == 0) waddr1 = 4'($urandom);
      wsrc1_val1 = $urandom; wsrc2_val1 = $urandom; wsrc1_val2 = $urandom; wsrc2_val2 = $urandom;
      wsrc1_tag1 = 6'($urandom_range(0, 7)); wsrc2_tag1 = 6'($urandom_range(0, 7));
      wsrc1_tag2 = 6'($urandom_range(0, 7)); wsrc2_tag2 = 6'($urandom_range(0, 7));
      wsrc1_rdy1 = 1'($urandom); wsrc2_rdy1 = 1'($urandom);
      wsrc1_rdy2 = 1'($urandom); wsrc2_rdy2 = 1'($urandom);
      wdst1 = 6'($urandom); wdst2 = 6'($urandom); wctl1 = 8'($urandom); wctl2 = 8'($urandom);
      wspec1 = 4'($urandom); wspec2 = 4'($urandom);
      cdb_v0 = ($urandom_range(0, 9) < 4); cdb_tag0 = 6'($urandom_range(0, 7)); cdb_data0 = $urandom;
      cdb_v1 = ($urandom_range(0, 9) < 4); cdb_tag1 = 6'($urandom_range(0, 7)); cdb_data1 = $urandom;
      iss_ready = ($urandom_range(0, 9) < 6);
      flush_v = ($urandom_range(0, 19) == 0); flush_mask = 4'($urandom);
      clr_v = ($urandom_range(0, 9) == 0); clr_mask = 4'($urandom);
      #1;
      p = model_pick();
      checks++; if (iss_valid !== (p >= 0)) begin errors++;
        $display("FAIL rnd_valid cyc %0d: got %b want %b", c, iss_valid, (p >= 0)); end
      checks++; if (busy !== model_busy()) begin errors++;
        $display("FAIL rnd_busy cyc %0d: got %h want %h", c, busy, model_busy()); end
      checks++; if (err !== m_err) begin errors++;
        $display("FAIL rnd_err cyc %0d: got %b want %b", c, err, m_err); end
      if (p >= 0) begin
        checks++;
        if ({iss_op1, iss_op2, iss_dst, iss_ctl, iss_spec} !== {m[p].v1, m[p].v2, m[p].dst, m[p].ctl, m[p].spec}) begin
          errors++;
          $display("FAIL rnd_payload cyc %0d entry %0d: got %h %h %h %h %h want %h %h %h %h %h", c, p,
                   iss_op1, iss_op2, iss_dst, iss_ctl, iss_spec, m[p].v1, m[p].v2, m[p].dst, m[p].ctl, m[p].spec);
        end
      end
      model_clock();
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    write1(4'd10, 32'h0, 32'h0, 6'h00, 6'h00, 1, 1, 6'h0A, 8'h00, 4'h0);
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy[10] !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", busy[10]); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({busy, iss_valid, err} !== {16'h0, 1'b0, 1'b0}) begin errors++;
      $display("FAIL areset: got busy=%h v=%b err=%b want 0000 0 0", busy, iss_valid, err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_write_bypass();
    test_flush();
    test_full_err();
    test_release();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
